// File: rtl/axixfer_pkg.sv
// Shared types and constants for the AXI4-Lite word-copy master.
package axixfer_pkg;

    localparam int          WORD_BYTES = 4;
    localparam logic [3:0]  STRB_ALL   = 4'hF;
    localparam int          AXIL_AW    = 32;
    localparam int          AXIL_DW    = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        DONE
    } copy_state_t;

endpackage

// File: rtl/axil_copy_ctrl.sv
// AXI4-Lite master copying LEN words from SRC to DST, one read-then-write per word,
// ascending addresses, a single transaction outstanding at any time.
module axil_copy_ctrl
    import axixfer_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [AXIL_AW-1:0] src_addr,
    input  logic [AXIL_AW-1:0] dst_addr,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   count,
    output logic               AWVALID,
    input  logic               AWREADY,
    output logic [AXIL_AW-1:0] AWADDR,
    output logic               WVALID,
    input  logic               WREADY,
    output logic [AXIL_DW-1:0] WDATA,
    output logic [3:0]         WSTRB,
    input  logic               BVALID,
    output logic               BREADY,
    output logic               ARVALID,
    input  logic               ARREADY,
    output logic [AXIL_AW-1:0] ARADDR,
    input  logic               RVALID,
    output logic               RREADY,
    input  logic [AXIL_DW-1:0] RDATA
);

    copy_state_t        state;
    logic [AXIL_AW-1:0] src_base;
    logic [AXIL_AW-1:0] dst_base;
    logic [LEN_W-1:0]   len_reg;
    logic [AXIL_DW-1:0] data_reg;
    logic               aw_done;
    logic               w_done;

    logic [AXIL_AW-1:0] word_off;
    logic [LEN_W-1:0]   count_inc;
    logic               aw_hs;
    logic               w_hs;

    // Addresses derive from registered state only, so they are stable while VALID waits.
    assign word_off  = AXIL_AW'(count) * AXIL_AW'(WORD_BYTES);
    assign ARADDR    = src_base + word_off;
    assign AWADDR    = dst_base + word_off;
    assign WDATA     = data_reg;
    assign WSTRB     = STRB_ALL;
    assign count_inc = count + LEN_W'(1);
    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            src_base <= '0;
            dst_base <= '0;
            len_reg  <= '0;
            data_reg <= '0;
            count    <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            ARVALID  <= 1'b0;
            RREADY   <= 1'b0;
            AWVALID  <= 1'b0;
            WVALID   <= 1'b0;
            BREADY   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_base <= {src_addr[AXIL_AW-1:2], 2'b00};
                        dst_base <= {dst_addr[AXIL_AW-1:2], 2'b00};
                        len_reg  <= len;
                        count    <= '0;
                        if (len != '0) begin
                            ARVALID <= 1'b1;
                            state   <= RD_ADDR;
                        end else begin
                            state   <= DONE;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (RVALID) begin
                        data_reg <= RDATA;
                        RREADY   <= 1'b0;
                        AWVALID  <= 1'b1;
                        WVALID   <= 1'b1;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        state    <= WR;
                    end
                end
                WR: begin
                    // AW and W complete independently; leave once both have handshaken.
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        count  <= count_inc;
                        if (count_inc == len_reg) begin
                            state <= DONE;
                        end else begin
                            ARVALID <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    ar_stable: assert property (@(posedge clock) disable iff (!reset)
        ARVALID && !ARREADY |=> ARVALID && $stable(ARADDR));
    aw_stable: assert property (@(posedge clock) disable iff (!reset)
        AWVALID && !AWREADY |=> AWVALID && $stable(AWADDR));
    w_stable: assert property (@(posedge clock) disable iff (!reset)
        WVALID && !WREADY |=> WVALID && $stable(WDATA));

endmodule
